// File: rtl/stopwatch_core.sv
// MM:SS stopwatch counter driven by an asynchronous slow TICK, with start/stop/clear
// buttons and a lap-freeze display snapshot. All asynchronous inputs are synchronised onto CLK.
module stopwatch_core #(
    parameter int unsigned TICKS_PER_SEC = 2,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       BTN_START,
    input  logic       BTN_STOP,
    input  logic       BTN_CLR,
    input  logic       BTN_LAP,
    output logic [3:0] SEC_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] MIN_TENS,
    output logic       RUNNING,
    output logic       LAP_ACTIVE,
    output logic       OVF
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam int unsigned ARM = SYNC_STAGES + 1;

    logic [1:0]                   rst_pipe;
    logic                         rst_n;
    logic [4:0]                   raw;
    logic [4:0][SYNC_STAGES-1:0]  sync_q;
    logic [4:0]                   synced;
    logic [4:0]                   edge_q;
    logic [4:0]                   pulse;
    logic [2:0]                   arm_cnt;
    logic                         armed;
    logic                         tick_p, start_p, stop_p, clr_p, lap_p;

    state_t     state_q, state_d;
    logic [7:0] presc_q;
    logic [3:0] so_q, st_q, mo_q, mt_q;
    logic [3:0] so_d, st_d, mo_d, mt_d;
    logic [3:0] snap_so, snap_st, snap_mo, snap_mt;
    logic       lap_q, ovf_q;
    logic       so_w, st_w, mo_w, mt_w;
    logic       clr_go, count_tick, sec_inc, lap_tog;

    // Asynchronous assert, synchronous release.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rst_pipe <= '0;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    assign raw = {BTN_LAP, BTN_CLR, BTN_STOP, BTN_START, TICK};

    always_comb begin
        synced = '0;
        for (int unsigned i = 0; i < 5; i++) synced[i] = sync_q[i][SYNC_STAGES-1];
    end

    // Pulses stay masked until the chain has filled, so inputs held high across reset release are not seen as edges.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            edge_q  <= '0;
            arm_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++)
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            edge_q <= synced;
            if (!armed) arm_cnt <= arm_cnt + 3'd1;
        end
    end

    assign armed = (arm_cnt == 3'(ARM));
    assign pulse = synced & ~edge_q & {5{armed}};
    assign {lap_p, clr_p, stop_p, start_p, tick_p} = pulse;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_p) state_d = RUN;
            RUN:     if (clr_p) state_d = IDLE; else if (stop_p) state_d = PAUSE;
            PAUSE:   if (clr_p) state_d = IDLE; else if (start_p) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign clr_go     = clr_p && (state_q != IDLE);
    assign count_tick = (state_q == RUN) && tick_p && !clr_p && !stop_p;
    assign sec_inc    = count_tick && (presc_q == 8'(TICKS_PER_SEC - 1));
    assign lap_tog    = lap_p && (state_q != IDLE);

    // Whole carry chain resolved combinationally so every digit updates on the same edge.
    always_comb begin
        so_w = (so_q == 4'd9);
        st_w = so_w && (st_q == 4'd5);
        mo_w = st_w && (mo_q == 4'd9);
        mt_w = mo_w && (mt_q == 4'd5);
        so_d = so_w ? '0 : so_q + 4'd1;
        st_d = so_w ? (st_w ? '0 : st_q + 4'd1) : st_q;
        mo_d = st_w ? (mo_w ? '0 : mo_q + 4'd1) : mo_q;
        mt_d = mo_w ? (mt_w ? '0 : mt_q + 4'd1) : mt_q;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            {so_q, st_q, mo_q, mt_q} <= '0;
            {snap_so, snap_st, snap_mo, snap_mt} <= '0;
            lap_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (clr_go) begin
            presc_q <= '0;
            {so_q, st_q, mo_q, mt_q} <= '0;
            {snap_so, snap_st, snap_mo, snap_mt} <= '0;
            lap_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (count_tick) presc_q <= sec_inc ? '0 : presc_q + 8'd1;
            if (sec_inc) begin
                {so_q, st_q, mo_q, mt_q} <= {so_d, st_d, mo_d, mt_d};
                if (mt_w) ovf_q <= 1'b1;
            end
            if (lap_tog) begin
                lap_q <= !lap_q;
                if (!lap_q) {snap_so, snap_st, snap_mo, snap_mt} <= {so_q, st_q, mo_q, mt_q};
            end
        end
    end

    assign SEC_ONES   = lap_q ? snap_so : so_q;
    assign SEC_TENS   = lap_q ? snap_st : st_q;
    assign MIN_ONES   = lap_q ? snap_mo : mo_q;
    assign MIN_TENS   = lap_q ? snap_mt : mt_q;
    assign RUNNING    = (state_q == RUN);
    assign LAP_ACTIVE = lap_q;
    assign OVF        = ovf_q;

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter TICKS_PER_SEC, default 2, sets the number of TICK rising edges per counted second; legal range 1..255.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on TICK and buttons; legal range 2..3.
REQ-003 Port CLK  input  1  system clock, 5 MHz board clock; the only clock in the block.
REQ-004 Port RST  input  1  asynchronous, active-low reset.
REQ-005 Port TICK  input  1  divided slow clock from the upstream divider, treated as asynchronous data and never used as a clock.
REQ-006 Port BTN_START  input  1  start/resume request, level, asynchronous.
REQ-007 Port BTN_STOP  input  1  pause request, level, asynchronous.
REQ-008 Port BTN_CLR  input  1  clear request, level, asynchronous.
REQ-009 Port BTN_LAP  input  1  lap freeze/release toggle, level, asynchronous.
REQ-010 Port SEC_ONES  output  4  displayed seconds units, BCD 0..9.
REQ-011 Port SEC_TENS  output  4  displayed seconds tens, BCD 0..5.
REQ-012 Port MIN_ONES  output  4  displayed minutes units, BCD 0..9.
REQ-013 Port MIN_TENS  output  4  displayed minutes tens, BCD 0..5.
REQ-014 Port RUNNING  output  1  high while the FSM is in RUN.
REQ-015 Port LAP_ACTIVE  output  1  high while the display is frozen.
REQ-016 Port OVF  output  1  sticky wrap flag, set on 59:59 -> 00:00.

Function
REQ-017 TICK and all four buttons SHALL each pass through SYNC_STAGES flops on CLK, followed by one extra flop for rising-edge detection, producing one-CLK pulses tick_p, start_p, stop_p, clr_p, lap_p.
REQ-018 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-019 IDLE: start_p -> RUN; all other pulses ignored, except lap_p which is ignored.
REQ-020 RUN: stop_p -> PAUSE; clr_p -> IDLE.
REQ-021 PAUSE: start_p -> RUN; clr_p -> IDLE.
REQ-022 Priority for pulses in the same cycle SHALL be clr_p > stop_p > start_p.
REQ-023 Entering IDLE via clr_p SHALL zero the prescaler, all four digits, OVF and LAP_ACTIVE in the following cycle.
REQ-024 An 8-bit prescaler SHALL increment on tick_p only in RUN; when it would reach TICKS_PER_SEC it SHALL reset to 0 and produce a one-cycle sec_inc.
REQ-025 Prescaler and digits SHALL hold their values in PAUSE; resuming SHALL continue from the held prescaler value.
REQ-026 sec_inc SHALL advance SEC_ONES; 9 wraps to 0 with carry to SEC_TENS; SEC_TENS 5 wraps to 0 with carry to MIN_ONES; MIN_ONES 9 wraps with carry to MIN_TENS; MIN_TENS 5 wraps to 0 and sets OVF.
REQ-027 All digit updates from one sec_inc SHALL land in the same CLK cycle, so no intermediate value is ever visible.
REQ-028 Latency: a TICK rising edge SHALL change the internal count no later than SYNC_STAGES+2 CLK cycles after it.
REQ-029 lap_p in RUN or PAUSE SHALL toggle LAP_ACTIVE.
REQ-030 While LAP_ACTIVE=1, the outputs SHALL show a snapshot register captured on the freezing lap_p; the internal count keeps running.
REQ-031 While LAP_ACTIVE=0, the outputs SHALL show the live count.
REQ-032 A tick_p and clr_p in the same cycle SHALL give a clear, with no increment.
REQ-033 A tick_p coincident with stop_p SHALL be dropped.
REQ-034 Digit registers SHALL never hold a non-BCD value or a tens digit > 5.

Reset
REQ-035 RST low SHALL asynchronously force: FSM=IDLE; prescaler=0; all digits and snapshot=0; RUNNING=0; LAP_ACTIVE=0; OVF=0; all synchronizer and edge flops=0.
REQ-036 Release of RST SHALL be synchronous to CLK; a TICK or button held high across release SHALL NOT produce a pulse.
REQ-037 RST asserted mid-count SHALL take effect without waiting for a CLK edge.

Verification
REQ-038 Reset, start_p, then 2 TICK edges (TICKS_PER_SEC=2) -> 00:01, RUNNING=1.
REQ-039 Preload to 59:59 and run, then 2 TICK edges -> 00:00, OVF=1, OVF persists until clr_p.
REQ-040 Run to 00:05, stop_p, 10 TICK edges -> still 00:05, RUNNING=0; start_p plus 2 TICK edges -> 00:06.
REQ-041 Run to 00:10, lap_p, 6 TICK edges -> display 00:10; lap_p -> display 00:13.
REQ-042 clr_p and a TICK edge in the same cycle at 00:07 -> 00:00, IDLE, no increment.
REQ-043 RST pulsed low mid-run with TICK held high -> all outputs 0 immediately; no count after release until a new TICK edge and start_p.
